display_feeder: RTL and testbench

DISPLAY_FEEDER -- requirements
Module: display_feeder

---
 rtl/display_feeder.sv | 187 ++++++++++++++++++
 tb/tb_display_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_feeder.sv
`default_nettype none
// ============================================================================
// Module      : display_feeder
// Description : Takes 14-bit binary values from a write strobe. Saturates them
//               at 9999 and converts them to four BCD digits with a sequential
//               shift-add-3 converter. Hands each result to a downstream hex
//               display driver using a latch/busy handshake.
//               A one-entry pending buffer keeps only the most recent value.
//               Optional build macro DISPLAY_FEEDER_RATE_LIMIT_EN inserts a
//               GAP state of UPDATE_GAP idle clocks after each update.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               value_wr   - one-cycle write strobe for value_in
//               value_in   - unsigned binary value to display
//               hex_busy   - busy flag from the downstream driver
//               data_latch - one-cycle update request to the driver
//               data_out   - {thousands, hundreds, tens, units} BCD digits
//               ovf        - data_out holds a saturated value
//               busy       - block is working or holds a pending value
// Revision    : 1.0 - initial release
// ============================================================================
module display_feeder #(
    parameter int UPDATE_GAP = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        value_wr,
    input  logic [13:0] value_in,
    input  logic        hex_busy,
    output logic        data_latch,
    output logic [15:0] data_out,
    output logic        ovf,
    output logic        busy
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CONVERT   = 3'd1;
    localparam logic [2:0] c_WAIT_SINK = 3'd2;
    localparam logic [2:0] c_LATCH     = 3'd3;
    localparam logic [2:0] c_WAIT_ACK  = 3'd4;
    localparam logic [2:0] c_WAIT_DONE = 3'd5;
    localparam logic [2:0] c_GAP       = 3'd6;

    localparam logic [13:0] c_SAT_MAX   = 14'd9999;
    localparam logic [3:0]  c_CONV_LAST = 4'd13;   // 14 shift steps
    localparam logic [3:0]  c_ACK_LAST  = 4'd3;    // 4 cycles of ack wait

    logic [2:0]  r_state;
    logic        r_pending;
    logic [13:0] r_buf;
    logic [13:0] r_work;
    logic [15:0] r_bcd;
    logic        r_work_ovf;
    logic [3:0]  r_cnt;
    logic        r_data_latch;
    logic [15:0] r_data_out;
    logic        r_ovf;

    logic        w_load;
    logic [13:0] w_load_val;
    logic        w_load_sat;
    logic [15:0] w_bcd_adj;

`ifdef DISPLAY_FEEDER_RATE_LIMIT_EN
    localparam int c_GAP_CYCLES = (UPDATE_GAP < 1) ? 1 : UPDATE_GAP;
    localparam int c_GAP_W      = $clog2(c_GAP_CYCLES + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_CYCLES - 1);
    logic [c_GAP_W-1:0] r_gap;
`else
    logic w_unused_gap;
    assign w_unused_gap = (UPDATE_GAP > 0);
`endif

    // A pending value has priority over a same-cycle write; that write then
    // refills the buffer instead.
    assign w_load     = (r_state == c_IDLE) && (r_pending || value_wr);
    assign w_load_val = r_pending ? r_buf : value_in;
    assign w_load_sat = (w_load_val > c_SAT_MAX);

    // Add-3 correction applied to every digit >= 5 before each shift
    generate
        for (genvar g = 0; g < 4; g++) begin : g_digit
            assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                         r_bcd[4*g +: 4] + 4'd3 :
                                         r_bcd[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_pending    <= 1'b0;
            r_buf        <= '0;
            r_work       <= '0;
            r_bcd        <= '0;
            r_work_ovf   <= 1'b0;
            r_cnt        <= '0;
            r_data_latch <= 1'b0;
            r_data_out   <= 16'h0000;
            r_ovf        <= 1'b0;
`ifdef DISPLAY_FEEDER_RATE_LIMIT_EN
            r_gap        <= '0;
`endif
        end else begin
            r_data_latch <= 1'b0;

            // Pending buffer: any write lands here, except the one case where
            // IDLE with an empty buffer takes the value straight into work.
            if (value_wr && !((r_state == c_IDLE) && !r_pending)) begin
                r_buf     <= value_in;
                r_pending <= 1'b1;
            end else if ((r_state == c_IDLE) && r_pending) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_load) begin
                        r_work     <= w_load_sat ? c_SAT_MAX : w_load_val;
                        r_work_ovf <= w_load_sat;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_state    <= c_CONVERT;
                    end
                end
                c_CONVERT: begin
                    r_bcd  <= {w_bcd_adj[14:0], r_work[13]};
                    r_work <= {r_work[12:0], 1'b0};
                    if (r_cnt == c_CONV_LAST) begin
                        r_state <= c_WAIT_SINK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_WAIT_SINK: begin
                    if (!hex_busy) begin
                        r_data_out   <= r_bcd;
                        r_ovf        <= r_work_ovf;
                        r_data_latch <= 1'b1;
                        r_state      <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT_ACK;
                end
                c_WAIT_ACK: begin
                    // A driver that never acknowledges must not stall us
                    if (hex_busy || (r_cnt == c_ACK_LAST)) begin
                        r_state <= c_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_WAIT_DONE: begin
                    if (!hex_busy) begin
`ifdef DISPLAY_FEEDER_RATE_LIMIT_EN
                        r_gap   <= '0;
                        r_state <= c_GAP;
`else
                        r_state <= c_IDLE;
`endif
                    end
                end
                c_GAP: begin
`ifdef DISPLAY_FEEDER_RATE_LIMIT_EN
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
`else
                    r_state <= c_IDLE;
`endif
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_latch = r_data_latch;
    assign data_out   = r_data_out;
    assign ovf        = r_ovf;
    assign busy       = (r_state != c_IDLE) || r_pending;

endmodule
`default_nettype wire

// File: tb/tb_display_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_feeder
// Description : Self-checking bench for display_feeder. A small hex-driver
//               model answers data_latch. Every latched result is compared
//               against a decimal-arithmetic reference of the written value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_feeder;

    logic        clk;
    logic        rst;
    logic        value_wr;
    logic [13:0] value_in;
    logic        hex_busy;
    logic        data_latch;
    logic [15:0] data_out;
    logic        ovf;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Driver model controls
    logic model_hold    = 1'b0;   // hold hex_busy high regardless
    logic model_respond = 1'b1;   // answer data_latch with a busy pulse
    int   model_len     = 3;      // busy pulse length in cycles
    int   fall_cyc      = 0;      // cycle at which the model dropped busy

    logic [16:0] seen_val[$];     // {ovf, data_out} at each latch pulse
    int          seen_cyc[$];

    display_feeder #(.UPDATE_GAP(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_wr   (value_wr),
        .value_in   (value_in),
        .hex_busy   (hex_busy),
        .data_latch (data_latch),
        .data_out   (data_out),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_latch === 1'b1) begin
            seen_val.push_back({ovf, data_out});
            seen_cyc.push_back(cyc);
        end
    end

    initial begin : hex_model
        hex_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_hold) begin
                hex_busy = 1'b1;
            end else if (model_respond && data_latch === 1'b1) begin
                hex_busy = 1'b1;
                repeat (model_len) @(negedge clk);
                hex_busy = 1'b0;
                fall_cyc = cyc;
            end else begin
                hex_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: saturate at 9999, split into decimal digits
    function automatic logic [16:0] expect_of(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {(v > 9999) ? 1'b1 : 1'b0, 4'(s / 1000), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write strobe sampled by exactly one rising edge; wr_cyc is that edge
    task automatic write_val(input int v, output int wr_cyc);
        @(negedge clk);
        value_wr = 1'b1;
        value_in = 14'(v);
        @(negedge clk);
        value_wr = 1'b0;
        wr_cyc   = cyc;
    endtask

    task automatic expect_latch(input string tag, input int v, output int lat_cyc);
        logic [16:0] exp;
        logic [16:0] got;
        int budget;
        exp     = expect_of(v);
        budget  = 0;
        lat_cyc = -1;
        while (seen_val.size() == 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_seen"}, 32'(seen_val.size() > 0), 32'd1);
        if (seen_val.size() > 0) begin
            got     = seen_val.pop_front();
            lat_cyc = seen_cyc.pop_front();
            check({tag, "_data"}, 32'(got[15:0]), 32'(exp[15:0]));
            check({tag, "_ovf"}, 32'(got[16]), 32'(exp[16]));
        end
    endtask

    task automatic wait_idle(output int idle_cyc);
        int budget;
        budget = 0;
        @(negedge clk);
        while (busy !== 1'b0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("idle", 32'(busy), 32'd0);
        idle_cyc = cyc;
    endtask

    initial begin : stim
        int wr_c;
        int lat_c;
        int idle_c;
        int v;
        logic [16:0] exp;

        rst      = 1'b1;
        value_wr = 1'b0;
        value_in = '0;
        repeat (3) @(negedge clk);
        check("rst_latch", 32'(data_latch), 32'd0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic conversion and fixed latency
        write_val(1234, wr_c);
        expect_latch("v1234", 1234, lat_c);
        check("v1234_latency", 32'(lat_c - wr_c), 32'd15);
        wait_idle(idle_c);

        // Saturation, then a normal value clears ovf
        write_val(12000, wr_c);
        expect_latch("v12000", 12000, lat_c);
        wait_idle(idle_c);
        write_val(7, wr_c);
        expect_latch("v7", 7, lat_c);
        wait_idle(idle_c);

        // Random values and random driver busy lengths
        for (int i = 0; i < 10; i++) begin
            v         = int'($urandom_range(0, 16383));
            model_len = int'($urandom_range(1, 5));
            write_val(v, wr_c);
            expect_latch("rand", v, lat_c);
            wait_idle(idle_c);
            exp = expect_of(v);
            check("rand_hold", 32'(data_out), 32'(exp[15:0]));
        end

        // Latest-wins buffer while the driver is busy
        model_hold = 1'b1;
        @(negedge clk);
        write_val(1, wr_c);
        write_val(2, wr_c);
        write_val(3, wr_c);
        repeat (30) @(negedge clk);
        check("hold_nolatch", 32'(seen_val.size()), 32'd0);
        model_len  = 2;
        model_hold = 1'b0;
        expect_latch("lw_first", 1, lat_c);
        expect_latch("lw_second", 3, lat_c);
        wait_idle(idle_c);
        repeat (40) @(negedge clk);
        check("lw_count", 32'(seen_val.size()), 32'd0);

        // Reset in the middle of a conversion
        write_val(5555, wr_c);
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_nolatch", 32'(seen_val.size()), 32'd0);
        check("midrst_data_after", 32'(data_out), 32'h0);

        // First write after reset goes straight in
        write_val(42, wr_c);
        expect_latch("post_rst", 42, lat_c);
        check("post_rst_latency", 32'(lat_c - wr_c), 32'd15);
        wait_idle(idle_c);

        // Driver never acknowledges: LATCH, 4 cycles WAIT_ACK, WAIT_DONE, IDLE
        model_respond = 1'b0;
        write_val(77, wr_c);
        expect_latch("noack", 77, lat_c);
        wait_idle(idle_c);
        check("noack_return", 32'(idle_c - lat_c), 32'd6);
        write_val(88, wr_c);
        expect_latch("noack_next", 88, lat_c);
        wait_idle(idle_c);
        model_respond = 1'b1;

`ifdef DISPLAY_FEEDER_RATE_LIMIT_EN
        // Back-to-back writes are spaced by at least UPDATE_GAP after busy falls
        model_len = 3;
        write_val(111, wr_c);
        write_val(222, wr_c);
        expect_latch("gap_first", 111, lat_c);
        expect_latch("gap_second", 222, lat_c);
        check("gap_spacing", 32'((lat_c - fall_cyc) >= 20), 32'd1);
        wait_idle(idle_c);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
